// File: rtl/rack_jtag_pkg.sv
// Shared definitions for the rack JTAG master: opcodes, length limits, FSM encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents: OP_SHIFT/OP_SELECT opcodes, MAX_LEN/SEL_LEN bit limits,
// state_e FSM encoding, and command decode helpers used at accept time.
package rack_jtag_pkg;

  localparam logic [1:0] OP_SHIFT  = 2'b00;
  localparam logic [1:0] OP_SELECT = 2'b01;

  localparam int MAX_LEN = 32;
  localparam int SEL_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Commands that complete without any TTCK activity.
  function automatic logic is_noop(input logic [1:0] op, input logic [5:0] len);
    return op[1] || ((op == OP_SHIFT) && (len == 6'd0));
  endfunction

  // Index of the final bit of a command; SHIFT lengths above MAX_LEN clamp.
  // Only meaningful for commands that are not no-ops.
  function automatic logic [4:0] last_bit(input logic [1:0] op, input logic [5:0] len);
    logic [5:0] n;
    if (op == OP_SELECT) begin
      n = 6'(SEL_LEN);
    end else if (len > 6'(MAX_LEN)) begin
      n = 6'(MAX_LEN);
    end else begin
      n = len;
    end
    return 5'(n - 6'd1);
  endfunction

endpackage

// File: rtl/rack_jtag_tick.sv
// TTCK half-period divider: pulses tick_o on the last CLK cycle of each phase.
// Latency: tick_o asserts CLKDIV cycles after en_i rises; combinational from the count.
// Backpressure: none; dropping en_i or a tick reloads the count so it never wraps.
//
// Ports: CLK (clock), RST_B (sync active-low reset), en_i (phase active),
//        tick_o (one-cycle end-of-phase pulse).
module rack_jtag_tick #(
  parameter int CLKDIV = 4
) (
  input  logic CLK,
  input  logic RST_B,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLKDIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rack_jtag_master.sv
// Rack JTAG master: runs SHIFT / SELECT commands as TTCK/TTMS/TTDI bit sequences.
// Latency: accept edge to RSP_VALID is 1 + 2*CLKDIV*bits cycles, 1 cycle for no-ops.
// Backpressure: CMD_READY only in IDLE/DONE; one command in flight, no queuing.
//
// Ports: CLK, RST_B (sync active-low); CMD_VALID/CMD_READY handshake with
// CMD_OP, CMD_LEN, CMD_TMS, CMD_TDI; RSP_VALID pulse with RSP_TDO;
// TTCK, TTMS, TTDI, TCTRL_B drive the rack mux, TTDO returns chain data.
module rack_jtag_master
  import rack_jtag_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [5:0]  CMD_LEN,
  input  logic [31:0] CMD_TMS,
  input  logic [31:0] CMD_TDI,
  output logic        RSP_VALID,
  output logic [31:0] RSP_TDO,
  output logic        TTCK,
  output logic        TTMS,
  output logic        TTDI,
  output logic        TCTRL_B,
  input  logic        TTDO
);

  state_e      state_q;
  state_e      state_d;
  logic        rdy_en_q;   // holds CMD_READY low for the cycle right after reset
  logic        sel_q;
  logic [4:0]  last_q;
  logic [4:0]  bit_q;
  logic [31:0] tms_q;
  logic [31:0] tdi_q;
  logic [31:0] tdo_q;
  logic        ttms_q;     // TMS level held between bits and between commands

  logic        tick;
  logic        active;
  logic        accept;
  logic [4:0]  cur_idx;

  assign active  = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign accept  = CMD_VALID && CMD_READY;
  assign RSP_TDO = tdo_q;

  // SELECT shifts the mux enable MSB first, so walk TDI from bit 7 down.
  assign cur_idx = sel_q ? {2'b00, 3'(SEL_LEN - 1) - bit_q[2:0]} : bit_q;

  rack_jtag_tick #(
    .CLKDIV(CLKDIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_B (RST_B),
    .en_i  (active),
    .tick_o(tick)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE accepts like IDLE so back-to-back commands have no gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = is_noop(CMD_OP, CMD_LEN) ? ST_DONE : ST_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (tick) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) state_d = (bit_q == last_q) ? ST_DONE : ST_LOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    TTCK      = 1'b0;
    TTMS      = ttms_q;
    TTDI      = 1'b0;
    TCTRL_B   = 1'b1;
    RSP_VALID = 1'b0;
    CMD_READY = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        CMD_READY = rdy_en_q;
      end
      ST_LOW, ST_HIGH: begin
        TTCK    = (state_q == ST_HIGH);
        TTDI    = tdi_q[cur_idx];
        TCTRL_B = !sel_q;
        if (!sel_q) TTMS = tms_q[bit_q];
      end
      ST_DONE: begin
        RSP_VALID = 1'b1;
        CMD_READY = rdy_en_q;
      end
      default: ;
    endcase
  end

  // Command registers, bit counter and TDO capture.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      rdy_en_q <= 1'b0;
      sel_q    <= 1'b0;
      last_q   <= '0;
      bit_q    <= '0;
      tms_q    <= '0;
      tdi_q    <= '0;
      tdo_q    <= '0;
      ttms_q   <= 1'b1;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        sel_q  <= (CMD_OP == OP_SELECT);
        last_q <= last_bit(CMD_OP, CMD_LEN);
        tms_q  <= CMD_TMS;
        tdi_q  <= CMD_TDI;
        tdo_q  <= '0;
        bit_q  <= '0;
      end else begin
        // LOW->HIGH edge is the TTCK rising edge: capture TDO, latch TMS level.
        if ((state_q == ST_LOW) && tick && !sel_q) begin
          tdo_q[bit_q] <= TTDO;
          ttms_q       <= tms_q[bit_q];
        end
        if ((state_q == ST_HIGH) && tick && (bit_q != last_q)) begin
          bit_q <= bit_q + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rack_jtag_master.sv
module tb_rack_jtag_master;

  localparam int D = 2;

  logic        CLK = 1'b0;
  logic        RST_B;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [5:0]  CMD_LEN;
  logic [31:0] CMD_TMS;
  logic [31:0] CMD_TDI;
  logic        RSP_VALID;
  logic [31:0] RSP_TDO;
  logic        TTCK;
  logic        TTMS;
  logic        TTDI;
  logic        TCTRL_B;
  logic        TTDO;

  always #5 CLK = ~CLK;

  rack_jtag_master #(.CLKDIV(D)) dut (
    .CLK      (CLK),
    .RST_B    (RST_B),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_OP   (CMD_OP),
    .CMD_LEN  (CMD_LEN),
    .CMD_TMS  (CMD_TMS),
    .CMD_TDI  (CMD_TDI),
    .RSP_VALID(RSP_VALID),
    .RSP_TDO  (RSP_TDO),
    .TTCK     (TTCK),
    .TTMS     (TTMS),
    .TTDI     (TTDI),
    .TCTRL_B  (TCTRL_B),
    .TTDO     (TTDO)
  );

  // Cycle counter: after edge k it holds k.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Board models clocked by TTCK: rack mux enable register (shifted while
  // TCTRL_B is low), a 1-bit-delay scan chain and a TMS-ones TAP tracker.
  int         ttck_rises = 0;
  int         sel_rises  = 0;
  logic [7:0] mux_en     = 8'h00;
  logic       dly        = 1'b0;
  int         tms_ones   = 0;

  assign TTDO = dly;

  always @(posedge TTCK) begin
    ttck_rises <= ttck_rises + 1;
    if (TCTRL_B === 1'b0) begin
      sel_rises <= sel_rises + 1;
      mux_en    <= {mux_en[6:0], TTDI};
    end else begin
      dly      <= TTDI;
      tms_ones <= (TTMS === 1'b1) ? ((tms_ones < 7) ? tms_ones + 1 : tms_ones) : 0;
    end
  end

  // Response capture.
  int          rsp_cnt = 0;
  logic [31:0] rsp_tdo [64];
  int          rsp_cyc [64];

  always @(negedge CLK) begin
    if (RSP_VALID === 1'b1 && rsp_cnt < 64) begin
      rsp_tdo[rsp_cnt] <= RSP_TDO;
      rsp_cyc[rsp_cnt] <= cyc;
      rsp_cnt          <= rsp_cnt + 1;
    end
  end

  // Scoreboard.
  typedef struct {
    logic [31:0] tdo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic chain_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected capture through the 1-bit-delay chain: bit 0 sees the chain's
  // prior content, bit i sees TDI bit i-1; bits at or above n read 0.
  function automatic logic [31:0] chain_exp(input logic [31:0] tdi, input int n, input logic d0);
    logic [63:0] v;
    v = ({32'h0, tdi} << 1) | {63'h0, d0};
    if (n < 32) v = v & ((64'd1 << n) - 64'd1);
    return v[31:0];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] tms,
                       input logic [31:0] tdi, input logic [31:0] etdo, input int elat,
                       input bit want, output int acc);
    exp_t e;
    CMD_OP    = op;
    CMD_LEN   = len;
    CMD_TMS   = tms;
    CMD_TDI   = tdi;
    CMD_VALID = 1'b1;
    for (int i = 0; i < 400 && CMD_READY !== 1'b1; i++) @(negedge CLK);
    check("cmd_accept", {31'h0, CMD_READY}, 32'h1);
    acc = cyc + 1;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    if (want) begin
      e.tdo = etdo;
      e.lat = elat;
      e.acc = acc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(output int rcyc);
    exp_t e;
    rcyc = 0;
    for (int i = 0; i < 400 && rsp_cnt <= rd_idx; i++) @(negedge CLK);
    check("rsp_seen", {31'h0, (rsp_cnt > rd_idx)}, 32'h1);
    if (rsp_cnt > rd_idx && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_tdo", rsp_tdo[rd_idx], e.tdo);
      check("rsp_lat", rsp_cyc[rd_idx] + 1 - e.acc, e.lat);
      rcyc = rsp_cyc[rd_idx];
      rd_idx++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, r1, r2, base, base_sel, n0;

    RST_B     = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'b00;
    CMD_LEN   = 6'd0;
    CMD_TMS   = 32'h0;
    CMD_TDI   = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ttck",  {31'h0, TTCK},      32'h0);
    check("rst_ttms",  {31'h0, TTMS},      32'h1);
    check("rst_ttdi",  {31'h0, TTDI},      32'h0);
    check("rst_tctrl", {31'h0, TCTRL_B},   32'h1);
    check("rst_ready", {31'h0, CMD_READY}, 32'h0);
    check("rst_rspv",  {31'h0, RSP_VALID}, 32'h0);
    check("rst_tdo",   RSP_TDO,            32'h0);
    @(negedge CLK);
    RST_B = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_rst", {31'h0, CMD_READY}, 32'h1);

    // SELECT 0x05.
    base     = ttck_rises;
    base_sel = sel_rises;
    issue(2'b01, 6'd0, 32'h0, 32'h05, 32'h0, 1 + 2*D*8, 1'b1, acc1);
    wait_rsp(r1);
    check("sel_ttck_cnt", ttck_rises - base, 8);
    check("sel_tctrl_cnt", sel_rises - base_sel, 8);
    check("sel_mux_en", {24'h0, mux_en}, 32'h05);
    check("sel_idle_tctrl", {31'h0, TCTRL_B}, 32'h1);

    // SHIFT 5 bits of TMS=1: TAP goes to Test-Logic-Reset.
    base = ttck_rises;
    issue(2'b00, 6'd5, 32'h1F, 32'h0, chain_exp(32'h0, 5, chain_prev), 1 + 2*D*5, 1'b1, acc1);
    wait_rsp(r1);
    chain_prev = 1'b0;
    check("tms_ttck_cnt", ttck_rises - base, 5);
    check("tap_tlr", {31'h0, (tms_ones >= 5)}, 32'h1);
    check("tms_idle_hold", {31'h0, TTMS}, 32'h1);

    // SHIFT 32 through the delay chain.
    issue(2'b00, 6'd32, 32'h0, 32'hA5C3_0F12, 32'h4B86_1E24, 1 + 2*D*32, 1'b1, acc1);
    wait_rsp(r1);
    chain_prev = 1'b1;
    check("idle_ttms_low", {31'h0, TTMS}, 32'h0);
    check("idle_ttdi", {31'h0, TTDI}, 32'h0);
    check("idle_ttck", {31'h0, TTCK}, 32'h0);

    // SHIFT with LEN above 32 clamps to 32 bits.
    base = ttck_rises;
    issue(2'b00, 6'd40, 32'h0, 32'h1234_5678, chain_exp(32'h1234_5678, 32, chain_prev),
          1 + 2*D*32, 1'b1, acc1);
    wait_rsp(r1);
    chain_prev = 1'b0;
    check("clamp_ttck_cnt", ttck_rises - base, 32);

    // No-ops: LEN=0 SHIFT, then reserved opcode.
    base = ttck_rises;
    issue(2'b00, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, acc1);
    issue(2'b11, 6'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, acc2);
    wait_rsp(r1);
    wait_rsp(r2);
    check("noop_ttck_cnt", ttck_rises - base, 0);

    // Back-to-back: SHIFT 3 then SELECT 0xA5 held valid throughout.
    base = ttck_rises;
    issue(2'b00, 6'd3, 32'h0, 32'h5, chain_exp(32'h5, 3, chain_prev), 1 + 2*D*3, 1'b1, acc1);
    issue(2'b01, 6'd0, 32'h0, 32'hA5, 32'h0, 1 + 2*D*8, 1'b1, acc2);
    wait_rsp(r1);
    wait_rsp(r2);
    chain_prev = 1'b1;
    check("b2b_accept_in_done", acc2, r1 + 1);
    check("b2b_mux_en", {24'h0, mux_en}, 32'hA5);
    check("b2b_ttck_cnt", ttck_rises - base, 11);

    // Reset in the middle of a 20-bit SHIFT.
    base = ttck_rises;
    issue(2'b00, 6'd20, 32'h0, 32'h000F_FFFF, 32'h0, 0, 1'b0, acc1);
    for (int i = 0; i < 400 && ttck_rises < base + 11; i++) @(negedge CLK);
    check("abort_reached_bit10", {31'h0, (ttck_rises >= base + 11)}, 32'h1);
    n0    = rsp_cnt;
    RST_B = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_ttck",  {31'h0, TTCK},      32'h0);
    check("abort_ttms",  {31'h0, TTMS},      32'h1);
    check("abort_tctrl", {31'h0, TCTRL_B},   32'h1);
    check("abort_rspv",  {31'h0, RSP_VALID}, 32'h0);
    check("abort_ready", {31'h0, CMD_READY}, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_B = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_ready_release", {31'h0, CMD_READY}, 32'h1);
    repeat (10) @(negedge CLK);
    check("abort_no_rsp", rsp_cnt, n0);

    check("sb_empty", exp_q.size(), 0);
    check("rsp_all_consumed", rsp_cnt, rd_idx);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
